// File: rtl/ram_scan_ctrl_pkg.sv
// Shared sizes and state encoding for the display RAM sequencer.
package ram_ctrl_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 4;
  localparam int RAM_DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    SCAN  = 1'b1
  } state_t;

endpackage

// File: rtl/ram_scan_ctrl_if.sv
// User write handshake, RAM port and scan display signals of the RAM sequencer.
interface ram_scan_ctrl_if;
  import ram_ctrl_pkg::*;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clear_req;
  logic              wr_ack;
  logic              busy;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr_en;
  logic [DATA_W-1:0] ram_wr_data;
  logic [DATA_W-1:0] ram_rd_data;

  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_data;

  modport master (
    input  wr_req, wr_addr, wr_data, clear_req, ram_rd_data,
    output wr_ack, busy, ram_addr, ram_wr_en, ram_wr_data, scan_addr, scan_data
  );

  modport slave (
    output wr_req, wr_addr, wr_data, clear_req, ram_rd_data,
    input  wr_ack, busy, ram_addr, ram_wr_en, ram_wr_data, scan_addr, scan_data
  );

endinterface

// File: rtl/ram_scan_ctrl_tick_gen.sv
// Scan-rate divider: one-cycle tick every TICK_DIV enabled cycles, restarts when disabled.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= RELOAD;
    end else if (!en || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/ram_scan_ctrl.sv
// Sole owner of the display RAM port: zero-fill after reset or clear, then a timed
// read scan with user writes slotted in, never two grants in a row.
//
// state | meaning
// CLEAR | zero-fill, one write per cycle, address = fill counter
// SCAN  | read scan_addr each cycle unless a user write is granted
module ram_scan_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input logic             clk,
  input logic             reset,
  ram_scan_ctrl_if.master bus
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fill_cnt, fill_cnt_nxt;

  logic [ADDR_W-1:0] ram_addr, ram_addr_nxt;
  logic              ram_wr_en, ram_wr_en_nxt;
  logic [DATA_W-1:0] ram_wr_data, ram_wr_data_nxt;
  logic              wr_ack, wr_ack_nxt;
  logic              busy, busy_nxt;
  logic              rd_issue, rd_issue_nxt;
  logic              rd_pend;

  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_data;

  logic scan_en, tick, clear_go, grant;

  assign scan_en  = (state == SCAN);
  assign clear_go = scan_en && bus.clear_req;
  // wr_ack high means last cycle was a grant, so this cycle must be a read
  assign grant    = scan_en && !bus.clear_req && bus.wr_req && !wr_ack;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (scan_en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= CLEAR;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    case (state)
      CLEAR: begin
        fill_cnt_nxt = fill_cnt + ADDR_W'(1);
        if (fill_cnt == ADDR_W'(RAM_DEPTH - 1)) state_nxt = SCAN;
      end
      SCAN: begin
        if (bus.clear_req) begin
          state_nxt    = CLEAR;
          fill_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = CLEAR;
        fill_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    ram_addr_nxt    = '0;
    ram_wr_en_nxt   = 1'b0;
    ram_wr_data_nxt = '0;
    wr_ack_nxt      = 1'b0;
    busy_nxt        = 1'b0;
    rd_issue_nxt    = 1'b0;
    case (state)
      CLEAR: begin
        ram_addr_nxt  = fill_cnt;
        ram_wr_en_nxt = 1'b1;
        busy_nxt      = 1'b1;
      end
      SCAN: begin
        if (bus.clear_req) begin
          busy_nxt = 1'b1;
        end else if (grant) begin
          ram_addr_nxt    = bus.wr_addr;
          ram_wr_en_nxt   = 1'b1;
          ram_wr_data_nxt = bus.wr_data;
          wr_ack_nxt      = 1'b1;
        end else begin
          ram_addr_nxt = scan_addr;
          rd_issue_nxt = 1'b1;
        end
      end
      default: busy_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr    <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_data <= '0;
      wr_ack      <= 1'b0;
      busy        <= 1'b1;
      rd_issue    <= 1'b0;
    end else begin
      ram_addr    <= ram_addr_nxt;
      ram_wr_en   <= ram_wr_en_nxt;
      ram_wr_data <= ram_wr_data_nxt;
      wr_ack      <= wr_ack_nxt;
      busy        <= busy_nxt;
      rd_issue    <= rd_issue_nxt;
    end
  end

  // A clear drops any read in flight and shows zero, matching the array being refilled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_addr <= '0;
      rd_pend   <= 1'b0;
      scan_data <= '0;
    end else if (clear_go) begin
      scan_addr <= '0;
      rd_pend   <= 1'b0;
      scan_data <= '0;
    end else begin
      if (tick) scan_addr <= scan_addr + ADDR_W'(1);
      rd_pend <= rd_issue;
      if (rd_pend) scan_data <= bus.ram_rd_data;
    end
  end

  assign bus.ram_addr    = ram_addr;
  assign bus.ram_wr_en   = ram_wr_en;
  assign bus.ram_wr_data = ram_wr_data;
  assign bus.wr_ack      = wr_ack;
  assign bus.busy        = busy;
  assign bus.scan_addr   = scan_addr;
  assign bus.scan_data   = scan_data;

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Directed bench for ram_scan_ctrl with a registered-read 32x4 RAM model, TICK_DIV=4.
module tb_ram_scan_ctrl;
  import ram_ctrl_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                exp_lat;
  } wr_vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [DATA_W-1:0] mem     [RAM_DEPTH];
  logic [DATA_W-1:0] exp_mem [RAM_DEPTH];
  wr_vec_t           vecs    [6];

  ram_scan_ctrl_if bus ();

  ram_scan_ctrl #(.TICK_DIV(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Power-up contents are non-zero so the zero-fill is observable.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_DEPTH; i++) mem[i] <= DATA_W'(8 + (i % 8));
    end else if (bus.ram_wr_en) begin
      mem[bus.ram_addr] <= bus.ram_wr_data;
    end
    bus.ram_rd_data <= mem[bus.ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_wr_en", bus.ram_wr_en, 0);
    check("rst_wr_data", bus.ram_wr_data, 0);
    check("rst_wr_ack", bus.wr_ack, 0);
    check("rst_busy", bus.busy, 1);
    check("rst_scan_addr", bus.scan_addr, 0);
    check("rst_scan_data", bus.scan_data, 0);
  endtask

  task automatic check_fill(input int n, input int clear_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("fill_wr_en", bus.ram_wr_en, 1);
      check("fill_addr", bus.ram_addr, i);
      check("fill_data", bus.ram_wr_data, 0);
      check("fill_busy", bus.busy, 1);
      check("fill_no_ack", bus.wr_ack, 0);
      bus.clear_req = (i == clear_at);
    end
    bus.clear_req = 1'b0;
    bus.wr_req    = 1'b0;
  endtask

  task automatic check_fill_done();
    @(negedge clk);
    check("done_wr_en", bus.ram_wr_en, 0);
    check("done_busy", bus.busy, 0);
    check("done_ack", bus.wr_ack, 0);
    check("done_rd_addr", bus.ram_addr, 0);
  endtask

  task automatic check_lap(input int steps);
    logic [ADDR_W-1:0] prev, nxt;
    int n;
    prev = bus.scan_addr;
    n    = 0;
    while (bus.scan_addr == prev && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("lap_align", (n < 8), 1);
    for (int s = 0; s < steps; s++) begin
      prev = bus.scan_addr;
      nxt  = prev + ADDR_W'(1);
      repeat (3) @(negedge clk);
      check("scan_hold", bus.scan_addr, prev);
      check("scan_data", bus.scan_data, exp_mem[prev]);
      @(negedge clk);
      check("scan_step", bus.scan_addr, nxt);
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int exp_lat);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_req  = 1'b1;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.wr_ack) seen = 1'b1;
    end
    check("wr_ack_seen", seen, 1);
    check("wr_ack_lat", lat, exp_lat);
    check("wr_port_en", bus.ram_wr_en, 1);
    check("wr_port_addr", bus.ram_addr, a);
    check("wr_port_data", bus.ram_wr_data, d);
    bus.wr_req = 1'b0;
    exp_mem[a] = d;
    @(negedge clk);
    check("wr_ack_pulse", bus.wr_ack, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [ADDR_W-1:0] a, nxt;

    vecs[0] = '{5'd5,  4'hA, 1};
    vecs[1] = '{5'd0,  4'h3, 1};
    vecs[2] = '{5'd31, 4'hC, 1};
    vecs[3] = '{5'd17, 4'h6, 1};
    vecs[4] = '{5'd17, 4'hD, 1};
    vecs[5] = '{5'd8,  4'h1, 1};

    bus.wr_req    = 1'b1;
    bus.wr_addr   = 5'd9;
    bus.wr_data   = 4'h5;
    bus.clear_req = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;

    // zero-fill with a request held throughout
    check_fill(32, -1);
    check_fill_done();
    check("fill_ram_9", mem[9], 0);
    for (int i = 0; i < RAM_DEPTH; i++) exp_mem[i] = '0;
    check_lap(33);

    for (int v = 0; v < 6; v++) do_write(vecs[v].addr, vecs[v].data, vecs[v].exp_lat);
    check("ram_5", mem[5], 4'hA);
    check("ram_17", mem[17], 4'hD);

    // continuous request: grants alternate with reads
    bus.wr_addr = 5'd3;
    bus.wr_data = 4'h9;
    bus.wr_req  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("held_ack", bus.wr_ack, (c % 2 == 0));
      check("held_wr_en", bus.ram_wr_en, (c % 2 == 0));
    end
    bus.wr_req = 1'b0;
    exp_mem[3] = 4'h9;
    @(negedge clk);
    check("held_ack_end", bus.wr_ack, 0);

    // write to the scanned address on the same edge as the tick
    n = 0;
    a = bus.scan_addr;
    while (bus.scan_addr == a && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("coinc_align", (n < 8), 1);
    a = bus.scan_addr;
    nxt = a + ADDR_W'(1);
    repeat (3) @(negedge clk);
    bus.wr_addr = a;
    bus.wr_data = 4'h7;
    bus.wr_req  = 1'b1;
    @(negedge clk);
    check("coinc_ack", bus.wr_ack, 1);
    check("coinc_addr", bus.ram_addr, a);
    check("coinc_tick", bus.scan_addr, nxt);
    bus.wr_req = 1'b0;
    exp_mem[a] = 4'h7;
    n = 0;
    while (bus.scan_addr != a && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rewind_found", bus.scan_addr, a);
    repeat (3) @(negedge clk);
    check("rewind_data", bus.scan_data, 4'h7);
    check_lap(33);

    // clear with a coincident request, clear_req pulsed again mid-fill
    bus.clear_req = 1'b1;
    bus.wr_req    = 1'b1;
    bus.wr_addr   = 5'd12;
    bus.wr_data   = 4'hF;
    @(negedge clk);
    bus.clear_req = 1'b0;
    check("clr_no_ack", bus.wr_ack, 0);
    check("clr_scan_addr", bus.scan_addr, 0);
    check_fill(32, 10);
    check_fill_done();
    check("clr_ram_12", mem[12], 0);
    for (int i = 0; i < RAM_DEPTH; i++) exp_mem[i] = '0;
    check_lap(33);

    // reset in the middle of a fill
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    check_fill(10, -1);
    reset = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    check_fill(32, -1);
    check_fill_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_scan_ctrl.md
# ram_scan_ctrl

Sequencer and arbiter for the 32x4 single-port block RAM. Owns the RAM's only address/write port. After reset it zero-fills the whole array, then continuously scans read addresses at a programmable tick rate for the HEX read display, and interleaves user write requests into the same port through a request/acknowledge handshake. It sits between the switch/key input logic and the RAM instance and drives the read-address and read-data HEX decoders.

## Interface
- ADDR_W, 5, RAM address width (depth = 2**ADDR_W = 32)
- DATA_W, 4, RAM data width
- TICK_DIV, 50_000_000, clk cycles per scan step (1 Hz at 50 MHz); must be >= 2
- clk  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- wr_req  in  1  user write request, level, held until wr_ack
- wr_addr  in  ADDR_W  write address, stable while wr_req high
- wr_data  in  DATA_W  write data, stable while wr_req high
- clear_req  in  1  single-cycle pulse, restart zero-fill
- ram_addr  out  ADDR_W  registered RAM address
- ram_wr_en  out  1  registered RAM write enable
- ram_wr_data  out  DATA_W  registered RAM write data
- ram_rd_data  in  DATA_W  RAM registered read data (1-edge latency)
- wr_ack  out  1  one-cycle pulse, write granted this cycle
- busy  out  1  high while zero-fill in progress
- scan_addr  out  ADDR_W  address currently shown
- scan_data  out  DATA_W  data read from scan_addr

## Operation
- States: CLEAR, SCAN. Reset enters CLEAR with fill counter = 0.
- CLEAR: each cycle issue write ram_addr=cnt, ram_wr_data=0, ram_wr_en=1; cnt increments; after cnt=31 issued, go SCAN. busy=1 throughout CLEAR. wr_req ignored (no ack, not queued).
- SCAN: port defaults to read of scan_addr (ram_wr_en=0). If wr_req=1 and previous cycle was not a grant, grant: ram_addr=wr_addr, ram_wr_data=wr_data, ram_wr_en=1, wr_ack=1. Grants never back-to-back: at least one read cycle between grants (scan never starved).
- Tick counter runs only in SCAN, cleared on entry; on count = TICK_DIV-1 it wraps to 0 and scan_addr increments, 31 wraps to 0. Tick advances regardless of a simultaneous grant.
- scan_data updates only from read cycles: captured from ram_rd_data on the edge after the RAM returns data for a read cycle; holds its value across write cycles.
- clear_req in SCAN: next state CLEAR, fill counter = 0, scan_addr = 0, tick counter = 0; a wr_req coincident with clear_req is not granted. clear_req during CLEAR ignored.
- Write to the address being scanned: scan_data shows new value after the next read cycle completes.

## Timing
- Reset values: ram_addr=0, ram_wr_en=0, ram_wr_data=0, wr_ack=0, busy=1, scan_addr=0, scan_data=0.
- First zero-fill write on first edge after reset deasserts; 32 consecutive write cycles; busy falls same edge ram_wr_en falls; first SCAN read on that edge.
- wr_req sampled high at edge k (eligible) -> ram_wr_en, wr_ack high after edge k; RAM writes at edge k+1. Requester drops wr_req after seeing wr_ack.
- Read: ram_addr presented after edge k -> ram_rd_data valid after k+1 -> scan_data updated after k+2.
- Reset asserted mid-CLEAR or mid-grant: all outputs return to reset values immediately; fill restarts at 0.

## Structure
- Package ram_ctrl_pkg: ADDR_W, DATA_W, RAM_DEPTH constants; state_t enum {CLEAR, SCAN}.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, reset, en, tick) for the scan divider; arbitration, fill counter and capture pipeline stay in ram_scan_ctrl.
- Bench uses TICK_DIV=4 and a behavioral 32x4 registered-read RAM model.

## Test plan
- Reset release -> ram_wr_en=1 for exactly 32 cycles, ram_addr 0..31, data 0, busy=1 then 0; no wr_ack though wr_req held high; scan_data=0.
- SCAN, no requests -> scan_addr steps every 4 cycles 0,1,..31,0; scan_data matches model contents.
- wr_req addr=5 data=0xA -> wr_ack one pulse, RAM[5]=0xA; when scan_addr reaches 5, scan_data=0xA two edges after read issue.
- wr_req held high continuously addr=3 -> grants alternate with reads (ack every other cycle), scan_data still updating.
- Write 0x7 to current scan_addr coincident with tick -> tick still advances; rewind scan to that addr shows 0x7; clear_req with wr_req high -> no ack, 32-cycle refill, all reads 0.
- Assert reset at fill count 10 -> outputs reset immediately; after release fill restarts at addr 0, full 32 cycles.
